// File: rtl/c2c_fifo_wr_arb.sv
// Round-robin burst arbiter: four requesters share one 21-bit FIFO write port.
// Optional C2C_ARB_SRCID_EN stamps the owner index into FIFO_WDATA[20:19].
module c2c_fifo_wr_arb #(
  parameter int BURST_MAX = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [3:0]  REQ,
  input  logic [20:0] REQ_DATA0,
  input  logic [20:0] REQ_DATA1,
  input  logic [20:0] REQ_DATA2,
  input  logic [20:0] REQ_DATA3,
  output logic [3:0]  ACK,
  output logic [3:0]  GNT,
  output logic        BUSY,
  output logic        FIFO_WREN,
  output logic [20:0] FIFO_WDATA,
  input  logic        FIFO_FULL
);

  localparam int BM =
    (BURST_MAX < 1 || BURST_MAX > 64) ? 64 : BURST_MAX;
  localparam logic [5:0] CNT_LAST = 6'(BM - 1);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t      r_state, w_state_nx;
  logic [3:0]  r_gnt, w_gnt_nx;
  logic [1:0]  r_own, w_own_nx;
  logic [1:0]  r_ptr, w_ptr_nx;
  logic [5:0]  r_cnt, w_cnt_nx;
  logic [1:0]  w_sel;
  logic        w_req_own;
  logic        w_wren;
  logic        w_last;
  logic [20:0] w_raw;

  // Scan ptr+4 (lowest) down to ptr+1 so the nearest set REQ wins.
  always_comb begin
    logic [1:0] idx;
    w_sel = '0;
    idx   = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = r_ptr + 2'(k);
      if (REQ[idx]) w_sel = idx;
    end
  end

  always_comb begin
    w_raw = '0;
    unique case (1'b1)
      r_gnt[0]: w_raw = REQ_DATA0;
      r_gnt[1]: w_raw = REQ_DATA1;
      r_gnt[2]: w_raw = REQ_DATA2;
      r_gnt[3]: w_raw = REQ_DATA3;
      default:  w_raw = '0;
    endcase
  end

  assign w_req_own = |(REQ & r_gnt);
  assign w_wren    = (r_state == S_GRANT) & w_req_own & ~FIFO_FULL;
  assign w_last    = w_wren & (r_cnt == CNT_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_own_nx   = r_own;
    w_ptr_nx   = r_ptr;
    w_cnt_nx   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (|REQ) begin
          w_state_nx = S_GRANT;
          w_gnt_nx   = 4'b0001 << w_sel;
          w_own_nx   = w_sel;
          w_cnt_nx   = '0;
        end
      end
      S_GRANT: begin
        if (!w_req_own || w_last) begin
          w_state_nx = S_IDLE;
          w_gnt_nx   = '0;
          w_ptr_nx   = r_own;
          w_cnt_nx   = '0;
        end else if (w_wren) begin
          w_cnt_nx = r_cnt + 6'd1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_gnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_own   <= '0;
      r_ptr   <= 2'd3;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_gnt   <= w_gnt_nx;
      r_own   <= w_own_nx;
      r_ptr   <= w_ptr_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  assign GNT       = r_gnt;
  assign BUSY      = (r_state == S_GRANT);
  assign FIFO_WREN = w_wren;
  assign ACK       = {4{w_wren}} & r_gnt;

`ifdef C2C_ARB_SRCID_EN
  assign FIFO_WDATA = BUSY ? {r_own, w_raw[18:0]} : '0;
`else
  assign FIFO_WDATA = w_raw;
`endif

endmodule

// File: tb/tb_c2c_fifo_wr_arb.sv
// Bench for c2c_fifo_wr_arb: requester models, write scoreboard,
// a vector table on a BURST_MAX=2 instance and multi-cycle sequences.
module tb_c2c_fifo_wr_arb;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  REQ;
  logic [20:0] D0, D1, D2, D3;
  logic        FULL;
  logic [3:0]  ACK, GNT;
  logic        BUSY, WREN;
  logic [20:0] WDATA;

  logic [3:0]  b_req;
  logic        b_full;
  logic [20:0] bd [4];
  logic [3:0]  b_ack, b_gnt;
  logic        b_busy, b_wren;
  logic [20:0] b_wdata;

  always #5 CLK = ~CLK;

  c2c_fifo_wr_arb #(.BURST_MAX(8)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ),
    .REQ_DATA0(D0), .REQ_DATA1(D1),
    .REQ_DATA2(D2), .REQ_DATA3(D3),
    .ACK(ACK), .GNT(GNT), .BUSY(BUSY),
    .FIFO_WREN(WREN), .FIFO_WDATA(WDATA),
    .FIFO_FULL(FULL)
  );

  c2c_fifo_wr_arb #(.BURST_MAX(2)) u_dut2 (
    .CLK(CLK), .RST_N(RST_N), .REQ(b_req),
    .REQ_DATA0(bd[0]), .REQ_DATA1(bd[1]),
    .REQ_DATA2(bd[2]), .REQ_DATA3(bd[3]),
    .ACK(b_ack), .GNT(b_gnt), .BUSY(b_busy),
    .FIFO_WREN(b_wren), .FIFO_WDATA(b_wdata),
    .FIFO_FULL(b_full)
  );

  int errors = 0;
  int checks = 0;

  int          left [4];
  logic [20:0] val [4];
  logic [22:0] sbq [$];

  logic [3:0]  s_gnt, s_ack;
  logic        s_busy, s_wren;
  logic [20:0] s_wdata;

  typedef struct {
    logic       full;
    logic [3:0] gnt;
    logic [3:0] ack;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [20:0] fwd(logic [1:0] s, logic [20:0] d);
`ifdef C2C_ARB_SRCID_EN
    return {s, d[18:0]};
`else
    return d;
`endif
  endfunction

  function automatic logic [1:0] src_of(logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic expect_words(int s, logic [20:0] base, int n);
    for (int i = 0; i < n; i++)
      sbq.push_back({2'(s), fwd(2'(s), base + 21'(i))});
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) REQ[i] = (left[i] > 0);
    D0 = val[0];
    D1 = val[1];
    D2 = val[2];
    D3 = val[3];
  endtask

  // One cycle: drive at posedge+1, sample at +2, ends at next posedge+1.
  task automatic cyc();
    logic [22:0] e;
    drive();
    #1;
    s_gnt   = GNT;
    s_ack   = ACK;
    s_busy  = BUSY;
    s_wren  = WREN;
    s_wdata = WDATA;
    chk("ack_owner", {28'd0, ACK}, WREN ? {28'd0, GNT} : 32'd0);
    if (WREN) begin
      if (sbq.size() == 0) begin
        chk("sb_unexpected_write", {11'd0, WDATA}, 32'hFFFFFFFF);
      end else begin
        e = sbq.pop_front();
        chk("sb_wdata", {9'd0, src_of(GNT), WDATA}, {9'd0, e});
      end
    end
    for (int i = 0; i < 4; i++)
      if (ACK[i]) begin
        left[i]--;
        val[i]++;
      end
    @(posedge CLK);
    #1;
  endtask

  task automatic drain(string nm);
    int k;
    k = 0;
    while ((left[0] | left[1] | left[2] | left[3]) != 0 && k < 200) begin
      cyc();
      k++;
    end
    chk({nm, "_drained"}, 32'(k < 200), 32'd1);
    cyc();
    cyc();
  endtask

  initial begin
    int acyc [$];
    int n;
    int k;
    logic [20:0] ew;

    RST_N = 1'b0;
    FULL = 1'b0;
    REQ = '0;
    D0 = '0; D1 = '0; D2 = '0; D3 = '0;
    b_req = '0;
    b_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      left[i] = 0;
      val[i] = '0;
      bd[i] = 21'h00100 + 21'(i);
    end

    tbl[0]  = '{1'b0, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 4'h1, 4'h1};
    tbl[2]  = '{1'b0, 4'h1, 4'h1};
    tbl[3]  = '{1'b0, 4'h0, 4'h0};
    tbl[4]  = '{1'b0, 4'h2, 4'h2};
    tbl[5]  = '{1'b0, 4'h2, 4'h2};
    tbl[6]  = '{1'b0, 4'h0, 4'h0};
    tbl[7]  = '{1'b0, 4'h4, 4'h4};
    tbl[8]  = '{1'b0, 4'h4, 4'h4};
    tbl[9]  = '{1'b0, 4'h0, 4'h0};
    tbl[10] = '{1'b0, 4'h8, 4'h8};
    tbl[11] = '{1'b0, 4'h8, 4'h8};
    tbl[12] = '{1'b0, 4'h0, 4'h0};
    tbl[13] = '{1'b1, 4'h1, 4'h0};
    tbl[14] = '{1'b0, 4'h1, 4'h1};
    tbl[15] = '{1'b0, 4'h1, 4'h1};
    tbl[16] = '{1'b0, 4'h0, 4'h0};

    // Reset state with requests pending
    REQ = 4'b1111;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_gnt", {28'd0, GNT}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_wren", {31'd0, WREN}, 32'd0);
    chk("rst_ack", {28'd0, ACK}, 32'd0);
    chk("rst_wdata", {11'd0, WDATA}, 32'd0);
    REQ = '0;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;

    // 1: single requester, two full bursts of 8
    left[0] = 16;
    val[0] = 21'h00001;
    expect_words(0, 21'h00001, 16);
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (s_ack[0]) acyc.push_back(c);
    end
    chk("t1_nacks", 32'(acyc.size()), 32'd16);
    if (acyc.size() == 16) begin
      chk("t1_first", 32'(acyc[0]), 32'd1);
      chk("t1_eighth", 32'(acyc[7]), 32'd8);
      chk("t1_ninth", 32'(acyc[8]), 32'd10);
      chk("t1_last", 32'(acyc[15]), 32'd17);
    end

    // 2: BURST_MAX=2 instance, all requesting, vector table
    b_req = 4'b1111;
    for (int r = 0; r < 17; r++) begin
      b_full = tbl[r].full;
      #1;
      ew = (tbl[r].gnt != 0) ?
           fwd(src_of(tbl[r].gnt), bd[src_of(tbl[r].gnt)]) : 21'd0;
      chk($sformatf("t2_gnt_r%0d", r), {28'd0, b_gnt}, {28'd0, tbl[r].gnt});
      chk($sformatf("t2_ack_r%0d", r), {28'd0, b_ack}, {28'd0, tbl[r].ack});
      chk($sformatf("t2_wren_r%0d", r), {31'd0, b_wren},
          {31'd0, |tbl[r].ack});
      chk($sformatf("t2_wdata_r%0d", r), {11'd0, b_wdata}, {11'd0, ew});
      @(posedge CLK);
      #1;
    end
    b_req = '0;
    b_full = 1'b0;

    // 3: owner 2 stalled by FULL mid-burst
    left[2] = 10;
    val[2] = 21'h00300;
    expect_words(2, 21'h00300, 10);
    repeat (3) cyc();
    chk("t3_pre_left", 32'(left[2]), 32'd8);
    FULL = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t3_full_gnt", {28'd0, s_gnt}, 32'h4);
      chk("t3_full_wren", {31'd0, s_wren}, 32'd0);
      chk("t3_full_ack", {28'd0, s_ack}, 32'd0);
    end
    FULL = 1'b0;
    n = 0;
    k = 0;
    while (k < 20) begin
      cyc();
      k++;
      if (s_wren) n++;
      else break;
    end
    chk("t3_resume_words", 32'(n), 32'd6);
    drain("t3");

    // 4: owner 1 drops REQ after 3 words
    left[1] = 3;
    val[1] = 21'h00400;
    expect_words(1, 21'h00400, 3);
    k = 0;
    while (left[1] != 0 && k < 50) begin
      cyc();
      k++;
    end
    chk("t4_acked", 32'(left[1]), 32'd0);
    left[0] = 1;
    val[0] = 21'h004A0;
    left[3] = 1;
    val[3] = 21'h004B0;
    expect_words(3, 21'h004B0, 1);
    expect_words(0, 21'h004A0, 1);
    cyc();
    chk("t4_drop_gnt", {28'd0, s_gnt}, 32'h2);
    chk("t4_drop_wren", {31'd0, s_wren}, 32'd0);
    cyc();
    chk("t4_idle_busy", {31'd0, s_busy}, 32'd0);
    cyc();
    chk("t4_next_gnt", {28'd0, s_gnt}, 32'h8);
    drain("t4");

    // 5: reset during a burst with cnt=4
    left[0] = 8;
    val[0] = 21'h00500;
    expect_words(0, 21'h00500, 4);
    k = 0;
    while (left[0] > 4 && k < 50) begin
      cyc();
      k++;
    end
    chk("t5_four_acked", 32'(left[0]), 32'd4);
    drive();
    #1;
    chk("t5_pre_busy", {31'd0, BUSY}, 32'd1);
    chk("t5_pre_wren", {31'd0, WREN}, 32'd1);
    #1;
    RST_N = 1'b0;
    #1;
    chk("t5_rst_gnt", {28'd0, GNT}, 32'd0);
    chk("t5_rst_busy", {31'd0, BUSY}, 32'd0);
    chk("t5_rst_wren", {31'd0, WREN}, 32'd0);
    chk("t5_rst_ack", {28'd0, ACK}, 32'd0);
    left[3] = 1;
    val[3] = 21'h005F0;
    drive();
    expect_words(0, 21'h00504, 4);
    expect_words(3, 21'h005F0, 1);
    @(posedge CLK);
    #3;
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    cyc();
    chk("t5_first_gnt", {28'd0, s_gnt}, 32'h1);
    drain("t5");

    // 6: full-scale data from requesters 1 and 3
    left[1] = 1;
    val[1] = 21'h1FFFFF;
    left[3] = 1;
    val[3] = 21'h1FFFFF;
    expect_words(1, 21'h1FFFFF, 1);
    expect_words(3, 21'h1FFFFF, 1);
    n = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (s_wren && s_gnt == 4'b0010) begin
        n++;
`ifdef C2C_ARB_SRCID_EN
        chk("t6_id1", {11'd0, s_wdata}, 32'h0FFFFF);
`else
        chk("t6_id1", {11'd0, s_wdata}, 32'h1FFFFF);
`endif
      end
      if (s_wren && s_gnt == 4'b1000) begin
        n++;
        chk("t6_id3", {11'd0, s_wdata}, 32'h1FFFFF);
      end
    end
    chk("t6_words", 32'(n), 32'd2);

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
